// File: rtl/ram_burst_reader.sv
// Burst reader for the simple dual-port RAM: walks count addresses from start_addr
// and streams the words out on valid/ready. Optional out_last via RAM_BURST_READER_LAST_EN.
module ram_burst_reader #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [AW-1:0]   start_addr,
   input  logic [CW-1:0]   count,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   raddr,
   input  logic [SIZE-1:0] read_data,
   output logic [SIZE-1:0] out_data,
   output logic            out_valid,
`ifdef RAM_BURST_READER_LAST_EN
   output logic            out_last,
`endif
   input  logic            out_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   issued_q, issued_d;
   logic [CW-1:0]   remaining_q, remaining_d;
   logic            need_q, need_d;
   logic            pending_q, pending_d;
   logic [SIZE-1:0] fifo_q [2];
   logic [SIZE-1:0] fifo_d [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      occ_q, occ_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef RAM_BURST_READER_LAST_EN
   logic            pend_last_q, pend_last_d;
   logic            last_q [2];
   logic            last_d [2];
`endif

   logic            hs;
   logic [1:0]      fill;
   logic            slot_ok;
   logic            do_issue;
   logic            last_addr;

   // Issuing latches the word at raddr into the RAM output (pending next cycle)
   // and advances raddr; a blocked address is simply re-read until it can issue.
   always_comb begin
      hs        = (occ_q != 2'd0) && out_ready;
      fill      = occ_q + {1'b0, pending_q};
      slot_ok   = (fill < 2'd2) || ((fill == 2'd2) && hs);
      do_issue  = (state_q == S_RUN) && need_q && slot_ok;
      last_addr = (issued_q >= count_q);

      state_d     = state_q;
      raddr_d     = raddr_q;
      count_d     = count_q;
      issued_d    = issued_q;
      remaining_d = remaining_q;
      need_d      = need_q;
      pending_d   = do_issue;
      fifo_d[0]   = fifo_q[0];
      fifo_d[1]   = fifo_q[1];
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
`ifdef RAM_BURST_READER_LAST_EN
      pend_last_d = do_issue && last_addr;
      last_d[0]   = last_q[0];
      last_d[1]   = last_q[1];
`endif

      if (do_issue) begin
         if (!last_addr) begin
            raddr_d  = (raddr_q == AW'(DEPTH - 1)) ? '0 : raddr_q + AW'(1);
            issued_d = issued_q + CW'(1);
         end else begin
            need_d = 1'b0;
         end
      end

      if (pending_q) begin
         fifo_d[wr_ptr_q] = read_data;
`ifdef RAM_BURST_READER_LAST_EN
         last_d[wr_ptr_q] = pend_last_q;
`endif
         wr_ptr_d = ~wr_ptr_q;
      end

      if (hs) begin
         rd_ptr_d    = ~rd_ptr_q;
         remaining_d = remaining_q - CW'(1);
      end

      occ_d = occ_q + {1'b0, pending_q} - {1'b0, hs};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  raddr_d     = start_addr;
                  issued_d    = CW'(1);
                  remaining_d = count;
                  count_d     = count;
                  need_d      = 1'b1;
                  state_d     = S_RUN;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_RUN: begin
            if (hs && (remaining_q == CW'(1))) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         raddr_q     <= '0;
         count_q     <= '0;
         issued_q    <= '0;
         remaining_q <= '0;
         need_q      <= 1'b0;
         pending_q   <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         occ_q       <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef RAM_BURST_READER_LAST_EN
         pend_last_q <= 1'b0;
         last_q[0]   <= 1'b0;
         last_q[1]   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         count_q     <= count_d;
         issued_q    <= issued_d;
         remaining_q <= remaining_d;
         need_q      <= need_d;
         pending_q   <= pending_d;
         fifo_q[0]   <= fifo_d[0];
         fifo_q[1]   <= fifo_d[1];
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef RAM_BURST_READER_LAST_EN
         pend_last_q <= pend_last_d;
         last_q[0]   <= last_d[0];
         last_q[1]   <= last_d[1];
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign raddr     = raddr_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = fifo_q[rd_ptr_q];
`ifdef RAM_BURST_READER_LAST_EN
   assign out_last  = out_valid && last_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a synchronous-read RAM model and an
// expected-word queue; out_last is checked when RAM_BURST_READER_LAST_EN is defined.
module tb_ram_burst_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] start_addr;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic [2:0] raddr;
   logic [7:0] read_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
`ifdef RAM_BURST_READER_LAST_EN
   logic       out_last;
`endif

   logic [7:0] mem [8];
   logic [7:0] exp_q [$];
   int         n_chk;
   int         n_err;

   ram_burst_reader #(.SIZE(8), .DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .raddr      (raddr),
      .read_data  (read_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
`ifdef RAM_BURST_READER_LAST_EN
      .out_last   (out_last),
`endif
      .out_ready  (out_ready)
   );

   // clock and synchronous-read RAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) read_data <= mem[raddr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one burst; bp=1 drives out_ready 1,0,0 repeating. spur>0 pulses a
   // second start in that cycle of the burst, which must be ignored.
   task automatic burst(input int addr, input int cnt, input int bp, input int spur);
      logic       stalled;
      logic [7:0] held;
      logic       got_done;
      logic [7:0] w;
      int         c;
      for (int k = 0; k < cnt; k++) exp_q.push_back(mem[(addr + k) % 8]);
      start      = 1'b1;
      start_addr = 3'(addr);
      count      = 4'(cnt);
      tick();
      start    = 1'b0;
      stalled  = 1'b0;
      held     = '0;
      got_done = 1'b0;
      c        = 1;
      while (c < 100 && !got_done) begin
         if (c == spur) begin
            start      = 1'b1;
            start_addr = 3'd5;
            count      = 4'd2;
         end else begin
            start = 1'b0;
         end
         out_ready = (bp == 0) ? 1'b1 : ((c % 3) == 1);
         if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
         end
         if (done) begin
            got_done = 1'b1;
            check("done_busy", 32'(busy), 32'd0);
            check("done_valid", 32'(out_valid), 32'd0);
            if (bp == 0) check("done_cycle", 32'(c), 32'(3 + cnt));
         end else if (out_valid && out_ready) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               check("extra_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
`ifdef RAM_BURST_READER_LAST_EN
               check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
`endif
               w = exp_q.pop_front();
               check("word", 32'(out_data), 32'(w));
            end
         end else if (out_valid) begin
            stalled = 1'b1;
            held    = out_data;
         end else begin
            stalled = 1'b0;
         end
         tick();
         c++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("got_done", 32'(got_done), 32'd1);
      check("words_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick();
      tick();
      check("after_busy", 32'(busy), 32'd0);
      check("after_valid", 32'(out_valid), 32'd0);
   endtask

   int exp_ra [4];
   int exp_wd [4];

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      out_ready  = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);

      // reset values
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      tick();

      // burst of 4 from address 2, exact cycle timing
      start = 1'b1; start_addr = 3'd2; count = 4'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      check("t1_raddr_c1", 32'(raddr), 32'd2);
      check("t1_busy_c1", 32'(busy), 32'd1);
      check("t1_valid_c1", 32'(out_valid), 32'd0);
      tick();
      check("t1_raddr_c2", 32'(raddr), 32'd3);
      check("t1_valid_c2", 32'(out_valid), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t1_valid", 32'(out_valid), 32'd1);
         check("t1_data", 32'(out_data), 32'h12 + 32'(i));
         check("t1_busy", 32'(busy), 32'd1);
         tick();
      end
      check("t1_done_c7", 32'(done), 32'd1);
      check("t1_busy_c7", 32'(busy), 32'd0);
      check("t1_valid_c7", 32'(out_valid), 32'd0);
      tick();
      check("t1_done_c8", 32'(done), 32'd0);

      // wrap: start 6, count 4
      exp_ra = '{6, 7, 0, 1};
      exp_wd = '{'h16, 'h17, 'h10, 'h11};
      start = 1'b1; start_addr = 3'd6; count = 4'd4;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (c <= 4) check("wrap_raddr", 32'(raddr), 32'(exp_ra[c-1]));
         if (c >= 3) check("wrap_data", 32'(out_data), 32'(exp_wd[c-3]));
         tick();
      end
      check("wrap_done", 32'(done), 32'd1);
      tick();

      // backpressure: full-depth burst with out_ready 1,0,0,...
      burst(0, 8, 1, -1);
      burst(5, 6, 1, -1);

      // count = 0
      start = 1'b1; start_addr = 3'd3; count = 4'd0;
      tick();
      start = 1'b0;
      check("c0_done_c1", 32'(done), 32'd1);
      check("c0_busy_c1", 32'(busy), 32'd0);
      check("c0_valid_c1", 32'(out_valid), 32'd0);
      tick();
      check("c0_done_c2", 32'(done), 32'd0);
      check("c0_valid_c2", 32'(out_valid), 32'd0);
      tick();
      check("c0_valid_c3", 32'(out_valid), 32'd0);

      // second start during a running burst is ignored
      burst(0, 3, 0, 2);

      // reset in cycle 4 of an 8-word burst
      start = 1'b1; start_addr = 3'd1; count = 4'd8; out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_raddr", 32'(raddr), 32'd0);
      tick();
      check("mrst_idle_valid", 32'(out_valid), 32'd0);
      burst(3, 5, 0, -1);

      // short bursts exercising the last-word flag
      burst(4, 3, 0, -1);
      burst(7, 1, 0, -1);
      burst(2, 2, 1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
